// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants, FSM encoding and helpers for the Ascon permutation
package ascon_pkg;

  localparam int NR_MAX = 12;

  localparam int X0_HI = 319;
  localparam int X0_LO = 256;
  localparam int X1_HI = 255;
  localparam int X1_LO = 192;
  localparam int X2_HI = 191;
  localparam int X2_LO = 128;
  localparam int X3_HI = 127;
  localparam int X3_LO = 64;
  localparam int X4_HI = 63;
  localparam int X4_LO = 0;

  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  typedef logic [1:0] fsm_t;
  localparam fsm_t ST_IDLE = 2'd0;
  localparam fsm_t ST_RUN  = 2'd1;
  localparam fsm_t ST_DONE = 2'd2;

  function automatic logic [63:0] rc(input logic [3:0] ir);
    return {56'h0, 4'hF - ir, ir};
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_seq_if.sv
// rtl/ascon_perm_seq_if.sv - start/ready/done handshake and state bus of the permutation sequencer
interface ascon_perm_seq_if;
  logic         start;
  logic [3:0]   rounds;
  logic         abort;
  logic [319:0] state_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [3:0]   round_idx;
  logic [319:0] state_out;

  modport master (
    output start, rounds, abort, state_in,
    input  ready, busy, done, round_idx, state_out
  );

  modport slave (
    input  start, rounds, abort, state_in,
    output ready, busy, done, round_idx, state_out
  );
endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant add, S-box layer, linear layer
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] state_in,
  input  logic [3:0]   ir,
  output logic [319:0] state_out
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] s0, s1, s2, s3, s4;

  always_comb begin
    x0 = state_in[X0_HI:X0_LO];
    x1 = state_in[X1_HI:X1_LO];
    x2 = state_in[X2_HI:X2_LO] ^ rc(ir);
    x3 = state_in[X3_HI:X3_LO];
    x4 = state_in[X4_HI:X4_LO];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    s0 = x0 ^ ror(x0, ROT_X0_A) ^ ror(x0, ROT_X0_B);
    s1 = x1 ^ ror(x1, ROT_X1_A) ^ ror(x1, ROT_X1_B);
    s2 = x2 ^ ror(x2, ROT_X2_A) ^ ror(x2, ROT_X2_B);
    s3 = x3 ^ ror(x3, ROT_X3_A) ^ ror(x3, ROT_X3_B);
    s4 = x4 ^ ror(x4, ROT_X4_A) ^ ror(x4, ROT_X4_B);

    state_out = {s0, s1, s2, s3, s4};
  end

endmodule

// File: rtl/ascon_perm_seq.sv
// rtl/ascon_perm_seq.sv - iterative p^b sequencer: one round per clock over a 320-bit state register
module ascon_perm_seq #(
  parameter int NR_MAX = ascon_pkg::NR_MAX
) (
  input  logic               clk,
  input  logic               rst,
  ascon_perm_seq_if.slave    io
);
  import ascon_pkg::*;

  localparam logic [3:0] NR_MAX_W = 4'(NR_MAX);

  fsm_t         fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   k_q, k_d;
  logic [3:0]   b_q, b_d;
  logic [3:0]   ir;
  logic [3:0]   b_clamped;
  logic [319:0] round_out;

  ascon_round u_round (
    .state_in  (state_q),
    .ir        (ir),
    .state_out (round_out)
  );

  // Clamping b keeps ir inside 0..NR_MAX-1, so the 4-bit subtraction never wraps.
  assign ir        = NR_MAX_W - b_q + k_q;
  assign b_clamped = (io.rounds > NR_MAX_W) ? NR_MAX_W : io.rounds;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    k_d     = k_q;
    b_d     = b_q;
    case (fsm_q)
      ST_IDLE: begin
        if (io.start) begin
          state_d = io.state_in;
          k_d     = 4'd0;
          b_d     = b_clamped;
          fsm_d   = (b_clamped == 4'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (io.abort) begin
          fsm_d = ST_IDLE;
          k_d   = 4'd0;
        end else begin
          state_d = round_out;
          k_d     = k_q + 4'd1;
          if (k_q == b_q - 4'd1) fsm_d = ST_DONE;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      k_q     <= 4'd0;
      b_q     <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      k_q     <= k_d;
      b_q     <= b_d;
    end
  end

  assign io.ready     = (fsm_q == ST_IDLE);
  assign io.busy      = (fsm_q == ST_RUN);
  assign io.done      = (fsm_q == ST_DONE);
  assign io.round_idx = (fsm_q == ST_RUN) ? ir : 4'd0;
  assign io.state_out = state_q;

endmodule
